apb_mailbox: RTL and testbench
==============================

Name: apb_mailbox

Overview:
APB completer that exchanges 32-bit words between software and an external valid/ready stream agent, such as an accelerator or a second core.
- It connects to one PSEL slot of the AXI2APB bridge in the peripherals block.
- It contains a TX FIFO (APB writes, stream reads) and an RX FIFO (stream writes, APB reads).
- It reports status and a maskable interrupt to the event unit.

Parameters:
APB_ADDR_WIDTH, 12, APB address width; only PADDR[4:2] is decoded.
BUFFER_DEPTH, 8, entries per FIFO; power of two, 2..128.

Ports:
HCLK  in  1  clock
HRESETn  in  1  reset, asynchronous, active-low
PADDR  in  APB_ADDR_WIDTH  APB address
PWDATA  in  32  write data
PWRITE  in  1  1=write
PSEL  in  1  slave select
PENABLE  in  1  access phase
PRDATA  out  32  read data
PREADY  out  1  always 1 (zero wait states)
PSLVERR  out  1  error response
tx_valid_o  out  1  TX FIFO head valid
tx_data_o  out  32  TX FIFO head
tx_ready_i  in  1  consumer accepts head
rx_valid_i  in  1  producer word valid
rx_data_i  in  32  producer word
rx_ready_o  out  1  RX FIFO can accept
irq_o  out  1  level interrupt

Behaviour:
- Access condition: acc = PSEL & PENABLE. All register side effects happen at the HCLK edge where acc=1.
- PRDATA and PSLVERR are combinational during acc. When acc=0 they are 0.
- Register map (by PADDR[4:2]):
  - 0 TXDATA (W): push PWDATA into the TX FIFO. If the TX FIFO is full, the word is dropped, PSLVERR=1, and ERR is set. A read of TXDATA returns 0.
  - 1 RXDATA (R): PRDATA = RX head, and the head is popped at the edge. If the RX FIFO is empty, PRDATA=0, PSLVERR=1, ERR is set, and no pop occurs. A write to RXDATA is ignored.
  - 2 STATUS (R):
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] ERR (sticky)
    - [15:8] tx_count, [23:16] rx_count, zero-extended
    - all other bits 0
  - 3 IRQ_EN (RW, bits [2:0], reset 0): [0] tx_empty, [1] rx_not_empty, [2] ERR.
  - 4 CLEAR (W, self-clearing, reads 0): [0] flush TX, [1] flush RX, [2] clear ERR.
  - 5..7: reads return 0, writes are ignored, PSLVERR=0.
- TX stream:
  - tx_valid_o = !tx_empty and tx_data_o = TX head, both from registers.
  - Pop when tx_valid_o & tx_ready_i.
- RX stream:
  - rx_ready_o = !rx_full.
  - Push when rx_valid_i & rx_ready_o.
- FIFO implementation: circular buffer with read/write pointers of width log2(DEPTH) that wrap modulo DEPTH. Count has width log2(DEPTH)+1, range 0..DEPTH.
- Simultaneous events:
  - Full/empty used for APB error checks is the value before the current edge.
  - A TX APB push while the TX FIFO is full errors, even if the stream pops in the same cycle.
  - A TX push and a stream pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
  - An RXDATA read while the RX FIFO is empty errors, even if the stream pushes in the same cycle; the pushed word is retained.
  - A flush overrides a push or pop on the same FIFO in the same cycle: the count goes to 0, pointers reset, and the push is discarded without error.
  - ERR set and CLEAR[2] in the same cycle: set wins.
- irq_o = |(IRQ_EN & {ERR, !rx_empty, tx_empty}). It is combinational from registers, with no edge detection.
- Reset values:
  - FIFOs empty, pointers 0, ERR=0, IRQ_EN=0.
  - Hence tx_valid_o=0, tx_data_o=0, rx_ready_o=1, irq_o=0, PRDATA=0, PSLVERR=0, PREADY=1.
  - Storage is not reset; the head is masked to 0 while empty.
  - A reset mid-transfer discards all contents immediately (asynchronous).

Test Plan:
1. Reset -> STATUS=0x0000_000A; tx_valid_o=0, rx_ready_o=1, irq_o=0.
2. Write TXDATA with 0x11,0x22,0x33 while tx_ready_i=0 -> STATUS[15:8]=3. Raise tx_ready_i -> tx_data_o shows 0x11, 0x22, 0x33 on consecutive cycles, then tx_valid_o=0.
3. With DEPTH=8 and tx_ready_i=0, do 9 TXDATA writes -> the 9th gets PSLVERR=1 and ERR=1, count stays 8. Draining yields exactly the first 8 words, in order.
4. Stream pushes 0xA5A5_0001..0xA5A5_0008 -> after 8 pushes rx_ready_o=0. RXDATA reads return the words in order with PSLVERR=0. A 9th read returns 0 with PSLVERR=1.
5. IRQ_EN=0b010, stream push of one word -> irq_o=1 the cycle after the push. One RXDATA read -> irq_o=0. Then IRQ_EN=0b100, force an error -> irq_o=1; CLEAR=0b100 -> irq_o=0.
6. Wrap and concurrency: TX holds 5 words; in one cycle, CLEAR[0] plus a stream pop -> count=0, tx_valid_o=0. Then 20 push/pop iterations with simultaneous APB push and stream pop -> order preserved across pointer wrap, count constant.

Source files
------------

// File: rtl/apb_mailbox.sv
// ---------------------------------------------------------------------------
// apb_mailbox
// APB completer that exchanges 32-bit words between software and an external
// valid/ready stream agent. APB writes to TXDATA feed the TX FIFO, which is
// drained by the stream consumer. The stream producer fills the RX FIFO, which
// software drains through RXDATA. Status and a maskable level interrupt are
// provided.
//
// Ports
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/
//   PSEL/PENABLE             APB request (only PADDR[4:2] decoded)
//   PRDATA/PREADY/PSLVERR    APB response (zero wait states)
//   tx_valid_o/tx_data_o/
//   tx_ready_i               TX stream out (head of TX FIFO)
//   rx_valid_i/rx_data_i/
//   rx_ready_o               RX stream in (into RX FIFO)
//   irq_o                    level interrupt
//
// Register map (PADDR[4:2])
//   0 TXDATA W   1 RXDATA R   2 STATUS R   3 IRQ_EN RW[2:0]   4 CLEAR W
// ---------------------------------------------------------------------------
module apb_mailbox #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int BUFFER_DEPTH   = 8
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0] PADDR,
   input  logic [31:0]               PWDATA,
   input  logic                      PWRITE,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   output logic [31:0]               PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR,
   output logic                      tx_valid_o,
   output logic [31:0]               tx_data_o,
   input  logic                      tx_ready_i,
   input  logic                      rx_valid_i,
   input  logic [31:0]               rx_data_i,
   output logic                      rx_ready_o,
   output logic                      irq_o
);

   localparam int PW = $clog2(BUFFER_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(BUFFER_DEPTH);

   // storage is deliberately not reset; heads are masked while empty
   logic [31:0]   tx_mem [BUFFER_DEPTH];
   logic [31:0]   rx_mem [BUFFER_DEPTH];
   logic [PW-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
   logic [CW-1:0] tx_count, rx_count;
   logic          err;
   logic [2:0]    irq_en;

   logic          tx_full, tx_empty, rx_full, rx_empty;
   logic          acc, wr_acc, rd_acc;
   logic [2:0]    idx;
   logic          tx_wr, tx_push, tx_err, tx_pop, tx_flush;
   logic          rx_rd, rx_pop, rx_err, rx_push, rx_flush;
   logic          clr_hit, err_clr, irq_wr;
   logic [31:0]   rx_head;
   logic [31:0]   status;
   logic          unused_paddr;

   assign tx_full  = (tx_count == FULL_CNT);
   assign tx_empty = (tx_count == '0);
   assign rx_full  = (rx_count == FULL_CNT);
   assign rx_empty = (rx_count == '0);

   assign acc    = PSEL & PENABLE;
   assign wr_acc = acc & PWRITE;
   assign rd_acc = acc & ~PWRITE;
   assign idx    = PADDR[4:2];
   assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

   // error checks use the full/empty state from before this edge
   assign tx_wr   = wr_acc && (idx == 3'd0);
   assign tx_push = tx_wr & ~tx_full;
   assign tx_err  = tx_wr & tx_full;
   assign rx_rd   = rd_acc && (idx == 3'd1);
   assign rx_pop  = rx_rd & ~rx_empty;
   assign rx_err  = rx_rd & rx_empty;
   assign irq_wr  = wr_acc && (idx == 3'd3);
   assign clr_hit = wr_acc && (idx == 3'd4);
   assign tx_flush = clr_hit & PWDATA[0];
   assign rx_flush = clr_hit & PWDATA[1];
   assign err_clr  = clr_hit & PWDATA[2];

   assign tx_pop  = tx_valid_o & tx_ready_i;
   assign rx_push = rx_valid_i & rx_ready_o;

   // TX FIFO control; a flush overrides any push/pop in the same cycle
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else if (tx_flush) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
         tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
      end
   end

   // RX FIFO control
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else if (rx_flush) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
         rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
      end
   end

   always_ff @(posedge HCLK) begin
      if (tx_push & ~tx_flush) tx_mem[tx_wr_ptr] <= PWDATA;
      if (rx_push & ~rx_flush) rx_mem[rx_wr_ptr] <= rx_data_i;
   end

   // sticky error: a new error in the same cycle as a clear wins
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         err    <= 1'b0;
         irq_en <= 3'd0;
      end else begin
         if (tx_err | rx_err) err <= 1'b1;
         else if (err_clr)    err <= 1'b0;
         if (irq_wr) irq_en <= PWDATA[2:0];
      end
   end

   assign tx_valid_o = ~tx_empty;
   assign tx_data_o  = tx_empty ? 32'd0 : tx_mem[tx_rd_ptr];
   assign rx_ready_o = ~rx_full;
   assign rx_head    = rx_empty ? 32'd0 : rx_mem[rx_rd_ptr];

   assign status = {8'd0, 8'(rx_count), 8'(tx_count), 3'd0,
                    err, rx_empty, rx_full, tx_empty, tx_full};

   always_comb begin
      PRDATA = 32'd0;
      if (rd_acc) begin
         case (idx)
            3'd1:    PRDATA = rx_head;
            3'd2:    PRDATA = status;
            3'd3:    PRDATA = {29'd0, irq_en};
            default: PRDATA = 32'd0;
         endcase
      end
   end

   assign PSLVERR = tx_err | rx_err;
   assign PREADY  = 1'b1;
   assign irq_o   = |(irq_en & {err, ~rx_empty, tx_empty});

endmodule

// File: tb/tb_apb_mailbox.sv
// ---------------------------------------------------------------------------
// tb_apb_mailbox
// Self-checking bench for apb_mailbox. Expected TX/RX words are queued as
// stimulus is driven and popped as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_apb_mailbox;

   localparam int AW    = 12;
   localparam int DEPTH = 8;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic [AW-1:0] PADDR = '0;
   logic [31:0]   PWDATA = '0;
   logic          PWRITE = 1'b0;
   logic          PSEL = 1'b0;
   logic          PENABLE = 1'b0;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic          tx_valid_o;
   logic [31:0]   tx_data_o;
   logic          tx_ready_i = 1'b0;
   logic          rx_valid_i = 1'b0;
   logic [31:0]   rx_data_i = '0;
   logic          rx_ready_o;
   logic          irq_o;

   apb_mailbox #(.APB_ADDR_WIDTH(AW), .BUFFER_DEPTH(DEPTH)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
      .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .tx_valid_o(tx_valid_o),
      .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i), .rx_valid_i(rx_valid_i),
      .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o), .irq_o(irq_o)
   );

   always #5 HCLK = ~HCLK;

   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] tx_q[$];
   logic [31:0] rx_q[$];
   logic [31:0] rd;
   logic        err;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // one APB transfer: setup, access (response sampled mid-access), release
   task automatic apb(input logic wr, input logic [2:0] idx, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic slverr);
      @(negedge HCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr;
      PADDR = AW'({idx, 2'b00}); PWDATA = wd;
      @(negedge HCLK);
      PENABLE = 1'b1;
      #1;
      rdata = PRDATA; slverr = PSLVERR;
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   // hold tx_ready_i high and expect every queued word on consecutive cycles
   task automatic drain_tx(input string name);
      @(negedge HCLK);
      tx_ready_i = 1'b1;
      while (tx_q.size() > 0) begin
         #4;
         n_checks++;
         if (tx_valid_o !== 1'b1 || tx_data_o !== tx_q[0])
            $display("FAIL %s_word: got valid=%b data=%h want valid=1 data=%h",
                     name, tx_valid_o, tx_data_o, tx_q[0]);
         else n_pass++;
         void'(tx_q.pop_front());
         @(negedge HCLK);
      end
      #4;
      n_checks++;
      if (tx_valid_o !== 1'b0) $display("FAIL %s_empty: got valid=%b want 0", name, tx_valid_o);
      else n_pass++;
      @(negedge HCLK);
      tx_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if (tx_valid_o !== 1'b0 || rx_ready_o !== 1'b1 || irq_o !== 1'b0 || tx_data_o !== 32'd0)
         $display("FAIL reset_stream: got txv=%b rxr=%b irq=%b txd=%h want 0 1 0 0",
                  tx_valid_o, rx_ready_o, irq_o, tx_data_o);
      else n_pass++;
      n_checks++;
      if (PRDATA !== 32'd0 || PSLVERR !== 1'b0 || PREADY !== 1'b1)
         $display("FAIL reset_apb: got prdata=%h slverr=%b pready=%b want 0 0 1",
                  PRDATA, PSLVERR, PREADY);
      else n_pass++;
      apb(1'b0, 3'd2, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0000_000A || err !== 1'b0)
         $display("FAIL reset_status: got %h err=%b want 0000000a err=0", rd, err);
      else n_pass++;
   endtask

   task automatic test_regs();
      apb(1'b1, 3'd3, 32'h0000_00FF, rd, err);
      apb(1'b0, 3'd3, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0000_0007) $display("FAIL irq_en_rb: got %h want 00000007", rd);
      else n_pass++;
      n_checks++;
      if (irq_o !== 1'b1) $display("FAIL irq_tx_empty: got %b want 1", irq_o);
      else n_pass++;
      apb(1'b1, 3'd3, 32'd0, rd, err);
      apb(1'b0, 3'd0, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'd0 || err !== 1'b0) $display("FAIL txdata_read: got %h err=%b want 0 0", rd, err);
      else n_pass++;
      apb(1'b1, 3'd6, 32'hFFFF_FFFF, rd, err);
      n_checks++;
      if (err !== 1'b0) $display("FAIL unmapped_wr: got slverr=%b want 0", err);
      else n_pass++;
      apb(1'b0, 3'd5, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'd0 || err !== 1'b0) $display("FAIL unmapped_rd: got %h err=%b want 0 0", rd, err);
      else n_pass++;
   endtask

   task automatic test_tx_basic();
      logic [31:0] words [3] = '{32'h11, 32'h22, 32'h33};
      for (int i = 0; i < 3; i++) begin
         apb(1'b1, 3'd0, words[i], rd, err);
         tx_q.push_back(words[i]);
         n_checks++;
         if (err !== 1'b0) $display("FAIL tx_push_err: got %b want 0", err);
         else n_pass++;
      end
      apb(1'b0, 3'd2, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0000_0308) $display("FAIL tx_status3: got %h want 00000308", rd);
      else n_pass++;
      drain_tx("tx_basic");
   endtask

   task automatic test_tx_overflow();
      for (int i = 0; i < DEPTH + 1; i++) begin
         apb(1'b1, 3'd0, 32'hC000_0000 + i, rd, err);
         if (i < DEPTH) tx_q.push_back(32'hC000_0000 + i);
         n_checks++;
         if (err !== (i == DEPTH))
            $display("FAIL tx_ovf_err%0d: got %b want %b", i, err, (i == DEPTH));
         else n_pass++;
      end
      apb(1'b0, 3'd2, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0000_0819) $display("FAIL tx_ovf_status: got %h want 00000819", rd);
      else n_pass++;
      drain_tx("tx_ovf");
      apb(1'b1, 3'd4, 32'h4, rd, err);
      apb(1'b0, 3'd2, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0000_000A) $display("FAIL err_clear: got %h want 0000000a", rd);
      else n_pass++;
   endtask

   task automatic test_rx();
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge HCLK);
         rx_valid_i = 1'b1;
         rx_data_i = 32'hA5A5_0001 + i;
         rx_q.push_back(32'hA5A5_0001 + i);
      end
      @(negedge HCLK);
      rx_valid_i = 1'b0;
      #1;
      n_checks++;
      if (rx_ready_o !== 1'b0) $display("FAIL rx_full_ready: got %b want 0", rx_ready_o);
      else n_pass++;
      apb(1'b0, 3'd2, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0008_0006) $display("FAIL rx_status: got %h want 00080006", rd);
      else n_pass++;
      for (int i = 0; i < DEPTH; i++) begin
         apb(1'b0, 3'd1, 32'd0, rd, err);
         n_checks++;
         if (rd !== rx_q[0] || err !== 1'b0)
            $display("FAIL rx_read%0d: got %h err=%b want %h err=0", i, rd, err, rx_q[0]);
         else n_pass++;
         void'(rx_q.pop_front());
      end
      apb(1'b0, 3'd1, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'd0 || err !== 1'b1) $display("FAIL rx_underflow: got %h err=%b want 0 1", rd, err);
      else n_pass++;
      apb(1'b1, 3'd4, 32'h4, rd, err);
   endtask

   task automatic test_irq();
      apb(1'b1, 3'd3, 32'h2, rd, err);
      @(negedge HCLK);
      rx_valid_i = 1'b1;
      rx_data_i = 32'hCAFE_0001;
      rx_q.push_back(32'hCAFE_0001);
      #1;
      n_checks++;
      if (irq_o !== 1'b0) $display("FAIL irq_pre_push: got %b want 0", irq_o);
      else n_pass++;
      @(negedge HCLK);
      rx_valid_i = 1'b0;
      #1;
      n_checks++;
      if (irq_o !== 1'b1) $display("FAIL irq_rx: got %b want 1", irq_o);
      else n_pass++;
      apb(1'b0, 3'd1, 32'd0, rd, err);
      n_checks++;
      if (rd !== rx_q[0] || irq_o !== 1'b0)
         $display("FAIL irq_rx_read: got %h irq=%b want %h irq=0", rd, irq_o, rx_q[0]);
      else n_pass++;
      void'(rx_q.pop_front());
      apb(1'b1, 3'd3, 32'h4, rd, err);
      apb(1'b0, 3'd1, 32'd0, rd, err);
      n_checks++;
      if (err !== 1'b1 || irq_o !== 1'b1) $display("FAIL irq_err: got err=%b irq=%b want 1 1", err, irq_o);
      else n_pass++;
      apb(1'b1, 3'd4, 32'h4, rd, err);
      n_checks++;
      if (irq_o !== 1'b0) $display("FAIL irq_err_clr: got %b want 0", irq_o);
      else n_pass++;
      apb(1'b1, 3'd3, 32'h0, rd, err);
   endtask

   task automatic test_back_to_back();
      logic [31:0] word;
      for (int i = 0; i < 5; i++) apb(1'b1, 3'd0, 32'hD000_0000 + i, rd, err);
      // flush and stream pop in the same edge
      @(negedge HCLK);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = AW'(12'h010); PWDATA = 32'h1;
      @(negedge HCLK);
      PENABLE = 1'b1; tx_ready_i = 1'b1;
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; tx_ready_i = 1'b0;
      n_checks++;
      if (tx_valid_o !== 1'b0) $display("FAIL flush_valid: got %b want 0", tx_valid_o);
      else n_pass++;
      apb(1'b0, 3'd2, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0000_000A) $display("FAIL flush_status: got %h want 0000000a", rd);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         apb(1'b1, 3'd0, 32'hE000_0000 + i, rd, err);
         tx_q.push_back(32'hE000_0000 + i);
      end
      for (int i = 0; i < 20; i++) begin
         word = 32'hB000_0000 + i;
         @(negedge HCLK);
         PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = '0; PWDATA = word;
         @(negedge HCLK);
         PENABLE = 1'b1; tx_ready_i = 1'b1;
         #1;
         n_checks++;
         if (tx_valid_o !== 1'b1 || tx_data_o !== tx_q[0] || PSLVERR !== 1'b0)
            $display("FAIL wrap_pop%0d: got valid=%b data=%h slverr=%b want 1 %h 0",
                     i, tx_valid_o, tx_data_o, PSLVERR, tx_q[0]);
         else n_pass++;
         void'(tx_q.pop_front());
         tx_q.push_back(word);
         @(posedge HCLK); #1;
         PSEL = 1'b0; PENABLE = 1'b0; tx_ready_i = 1'b0;
         apb(1'b0, 3'd2, 32'd0, rd, err);
         n_checks++;
         if (rd !== 32'h0000_0308) $display("FAIL wrap_count%0d: got %h want 00000308", i, rd);
         else n_pass++;
      end
      drain_tx("wrap");
   endtask

   task automatic test_async_reset();
      apb(1'b1, 3'd0, 32'h1234_5678, rd, err);
      apb(1'b1, 3'd3, 32'h7, rd, err);
      @(negedge HCLK);
      #2;
      HRESETn = 1'b0;
      #1;
      n_checks++;
      if (tx_valid_o !== 1'b0 || tx_data_o !== 32'd0 || irq_o !== 1'b0)
         $display("FAIL async_reset: got txv=%b txd=%h irq=%b want 0 0 0", tx_valid_o, tx_data_o, irq_o);
      else n_pass++;
      @(negedge HCLK);
      HRESETn = 1'b1;
      apb(1'b0, 3'd2, 32'd0, rd, err);
      n_checks++;
      if (rd !== 32'h0000_000A) $display("FAIL async_status: got %h want 0000000a", rd);
      else n_pass++;
   endtask

   initial begin
      repeat (3) @(negedge HCLK);
      HRESETn = 1'b1;
      test_reset();
      test_regs();
      test_tx_basic();
      test_tx_overflow();
      test_rx();
      test_irq();
      test_back_to_back();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
